// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: state encoding plus sizing and pipeline-latency constants for the matrix-multiply controller.
package mat_mul_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_FLUSH,
        S_OUT_FETCH,
        S_OUT_SEND
    } state_t;

    localparam int DEF_DIM_LOG = 1;
    localparam int BRAM_RD_LAT = 1;
    localparam int MAC_PIPE    = 2;

    function automatic int size_log(input int dim_log);
        return 2 * dim_log;
    endfunction
endpackage

// File: rtl/mat_mul_agu_cnt.sv
// mat_mul_agu_cnt: nested i/j/k product-loop counter (k innermost) with wrap flags.
module mat_mul_agu_cnt
    import mat_mul_pkg::*;
#(
    parameter int DIM_LOG = DEF_DIM_LOG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [DIM_LOG-1:0] i,
    output logic [DIM_LOG-1:0] j,
    output logic [DIM_LOG-1:0] k,
    output logic               k_last,
    output logic               last
);
    logic [3*DIM_LOG-1:0] idx;

    always_ff @(posedge clk)
        idx <= (rst || clr) ? '0 : en ? idx + (3*DIM_LOG)'(1) : idx;

    assign {i, j, k} = idx;
    assign k_last    = &k;
    assign last      = &idx;
endmodule

// File: rtl/mat_mul_ctrl.sv
// mat_mul_ctrl: load / i-j-k calculate / stream-out sequencer for the matrix-multiply accelerator.
// Define MAT_MUL_CTRL_PERF_CNT_EN to add the calc_cycles performance counter output.
module mat_mul_ctrl
    import mat_mul_pkg::*;
#(
    parameter int DIM_LOG  = DEF_DIM_LOG,
    parameter int SIZE_LOG = size_log(DIM_LOG)
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_aresetn,
    input  logic                sel,
    input  logic                start,
    input  logic                s00_axis_tvalid,
    input  logic                s00_axis_tlast,
    output logic                s00_axis_tready,
    input  logic                m00_axis_tready,
    output logic                m00_axis_tvalid,
    output logic                m00_axis_tlast,
    output logic                en_A,
    output logic                rw_A,
    output logic [SIZE_LOG-1:0] addr_A,
    output logic                en_B,
    output logic                rw_B,
    output logic [SIZE_LOG-1:0] addr_B,
    output logic                en_R,
    output logic                rw_R,
    output logic [SIZE_LOG-1:0] addr_R,
    output logic                mac_clear,
    output logic                mac_en,
    output logic                busy,
    output logic                done,
    output logic                load_err
`ifdef MAT_MUL_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         calc_cycles
`endif
);
    localparam int IJW = 2 * DIM_LOG;
    localparam logic [SIZE_LOG-1:0] FLUSH_LAST = SIZE_LOG'(MAC_PIPE - 1);

    state_t st, nxt;
    logic [SIZE_LOG-1:0] cnt;
    logic sel_q, calc, ld_a, ld_b, k_last, last_issue;
    logic [DIM_LOG-1:0] i, j, k;
    logic [BRAM_RD_LAT-1:0] mac_en_sr, mac_clr_sr;
    logic [MAC_PIPE-1:0] wr_sr;
    logic [MAC_PIPE-1:0][IJW-1:0] ij_sr;

    assign calc = st == S_CALC;
    assign ld_a = st == S_LOAD && s00_axis_tvalid && !sel_q;
    assign ld_b = st == S_LOAD && s00_axis_tvalid && sel_q;
    assign mac_en    = mac_en_sr[BRAM_RD_LAT-1];
    assign mac_clear = mac_clr_sr[BRAM_RD_LAT-1];

    mat_mul_agu_cnt #(.DIM_LOG(DIM_LOG)) u_agu (
        .clk    (s00_axi_aclk),
        .rst    (!s00_axi_aresetn),
        .clr    (st == S_IDLE),
        .en     (calc),
        .i      (i),
        .j      (j),
        .k      (k),
        .k_last (k_last),
        .last   (last_issue)
    );

    always_ff @(posedge s00_axi_aclk)
        st <= !s00_axi_aresetn ? S_IDLE : nxt;

    always_comb begin
        nxt             = st;
        busy            = st != S_IDLE;
        s00_axis_tready = st == S_LOAD;
        m00_axis_tvalid = st == S_OUT_SEND;
        m00_axis_tlast  = st == S_OUT_SEND && &cnt;
        en_A            = calc || ld_a;
        rw_A            = ld_a;
        addr_A          = calc ? {i, k} : (st == S_LOAD && !sel_q) ? cnt : '0;
        en_B            = calc || ld_b;
        rw_B            = ld_b;
        addr_B          = calc ? {k, j} : (st == S_LOAD && sel_q) ? cnt : '0;
        en_R            = wr_sr[MAC_PIPE-1] || st == S_OUT_FETCH;
        rw_R            = wr_sr[MAC_PIPE-1];
        addr_R          = wr_sr[MAC_PIPE-1] ? ij_sr[MAC_PIPE-1] :
                          (st == S_OUT_FETCH || st == S_OUT_SEND) ? cnt : '0;
        unique case (st)
            S_IDLE:      nxt = s00_axis_tvalid ? S_LOAD : start ? S_CALC : S_IDLE;
            S_LOAD:      nxt = (s00_axis_tvalid && (&cnt || s00_axis_tlast)) ? S_IDLE : S_LOAD;
            S_CALC:      nxt = last_issue ? S_FLUSH : S_CALC;
            S_FLUSH:     nxt = cnt == FLUSH_LAST ? S_OUT_FETCH : S_FLUSH;
            S_OUT_FETCH: nxt = S_OUT_SEND;
            S_OUT_SEND:  nxt = m00_axis_tready ? (&cnt ? S_IDLE : S_OUT_FETCH) : S_OUT_SEND;
            default:     nxt = S_IDLE;
        endcase
    end

    // cnt serves as load beat count, flush timer and output address in turn
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            cnt        <= '0;
            sel_q      <= 1'b0;
            load_err   <= 1'b0;
            done       <= 1'b0;
            mac_en_sr  <= '0;
            mac_clr_sr <= '0;
            wr_sr      <= '0;
            ij_sr      <= '0;
        end else begin
            mac_en_sr  <= BRAM_RD_LAT'({mac_en_sr, calc});
            mac_clr_sr <= BRAM_RD_LAT'({mac_clr_sr, calc && k == '0});
            wr_sr      <= MAC_PIPE'({wr_sr, calc && k_last});
            ij_sr      <= (MAC_PIPE * IJW)'({ij_sr, i, j});
            done       <= st == S_OUT_SEND && m00_axis_tready && &cnt;
            if (st == S_IDLE && s00_axis_tvalid)
                sel_q <= sel;
            if (st == S_LOAD && s00_axis_tvalid)
                load_err <= load_err || (&cnt != s00_axis_tlast);
            if (st == S_IDLE || (st == S_FLUSH && cnt == FLUSH_LAST))
                cnt <= '0;
            else if ((st == S_LOAD && s00_axis_tvalid) || st == S_FLUSH ||
                     (st == S_OUT_SEND && m00_axis_tready))
                cnt <= cnt + SIZE_LOG'(1);
        end
    end

`ifdef MAT_MUL_CTRL_PERF_CNT_EN
    always_ff @(posedge s00_axi_aclk)
        if (!s00_axi_aresetn || (st == S_IDLE && nxt == S_CALC))
            calc_cycles <= '0;
        else if (st == S_CALC || st == S_FLUSH)
            calc_cycles <= calc_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_mat_mul_ctrl.sv
// tb_mat_mul_ctrl: randomized bench for mat_mul_ctrl with BRAM and MAC models wired around it
// and a plain matrix-product reference.
module tb_mat_mul_ctrl;
    localparam int DIM_LOG  = 1;
    localparam int DIM      = 1 << DIM_LOG;
    localparam int SIZE     = DIM * DIM;
    localparam int SIZE_LOG = 2 * DIM_LOG;

    logic clk = 1'b0;
    logic aresetn = 1'b0, sel = 1'b0, start = 1'b0;
    logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
    logic [31:0] s_tdata = '0;
    logic s_tready, m_tvalid, m_tlast, en_A, rw_A, en_B, rw_B, en_R, rw_R;
    logic mac_clear, mac_en, busy, done, load_err;
    logic [SIZE_LOG-1:0] addr_A, addr_B, addr_R;
`ifdef MAT_MUL_CTRL_PERF_CNT_EN
    logic [31:0] calc_cycles;
`endif
    logic [14+3*SIZE_LOG-1:0] outs;

    logic [31:0] mem_a [SIZE] = '{default: '0};
    logic [31:0] mem_b [SIZE] = '{default: '0};
    logic [31:0] mem_r [SIZE] = '{default: '0};
    logic [31:0] ref_a [SIZE] = '{default: '0};
    logic [31:0] ref_b [SIZE] = '{default: '0};
    logic [31:0] ref_r [SIZE] = '{default: '0};
    logic [31:0] a_dout = '0, b_dout = '0, r_dout = '0, acc = '0;
    int r_writes = 0;
    int checks = 0;
    int errors = 0;
    logic err_m = 1'b0;

    always #5 clk = ~clk;

    mat_mul_ctrl #(.DIM_LOG(DIM_LOG)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .sel             (sel),
        .start           (start),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .en_A            (en_A),
        .rw_A            (rw_A),
        .addr_A          (addr_A),
        .en_B            (en_B),
        .rw_B            (rw_B),
        .addr_B          (addr_B),
        .en_R            (en_R),
        .rw_R            (rw_R),
        .addr_R          (addr_R),
        .mac_clear       (mac_clear),
        .mac_en          (mac_en),
        .busy            (busy),
        .done            (done),
        .load_err        (load_err)
`ifdef MAT_MUL_CTRL_PERF_CNT_EN
        ,
        .calc_cycles     (calc_cycles)
`endif
    );

    assign outs = {s_tready, m_tvalid, m_tlast, en_A, rw_A, addr_A, en_B, rw_B, addr_B,
                   en_R, rw_R, addr_R, mac_clear, mac_en, busy, done, load_err};

    // external datapath: slave tdata -> A/B, accumulator -> R, R data_out -> master tdata
    always @(posedge clk) begin
        if (en_A) begin
            if (rw_A) mem_a[addr_A] <= s_tdata;
            else a_dout <= mem_a[addr_A];
        end
        if (en_B) begin
            if (rw_B) mem_b[addr_B] <= s_tdata;
            else b_dout <= mem_b[addr_B];
        end
        if (en_R) begin
            if (rw_R) mem_r[addr_R] <= acc;
            else r_dout <= mem_r[addr_R];
        end
        if (mac_en) acc <= mac_clear ? a_dout * b_dout : acc + a_dout * b_dout;
        if (en_R && rw_R) r_writes <= r_writes + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic s, input int last_beat, input logic [31:0] vals [SIZE],
                        input logic with_start);
        int b = 0;
        int guard = 0;
        sel = s;
        start = with_start;
        s_tvalid = 1'b1;
        s_tdata = vals[0];
        s_tlast = last_beat == 0;
        #1 check("idle_tready", s_tready, 1'b0);
        tick();
        sel = ~s;
        start = 1'b0;
        while (b <= last_beat && guard < 64) begin
            guard++;
            s_tvalid = $urandom_range(0, 3) != 0;
            s_tdata = vals[b];
            s_tlast = b == last_beat;
            #1;
            check("load_tready", s_tready, 1'b1);
            if (s) check("load_strobe_b", {en_B, rw_B, addr_B, en_A}, {s_tvalid, s_tvalid, SIZE_LOG'(b), 1'b0});
            else   check("load_strobe_a", {en_A, rw_A, addr_A, en_B}, {s_tvalid, s_tvalid, SIZE_LOG'(b), 1'b0});
            if (s_tvalid) begin
                if (s) ref_b[b] = vals[b];
                else   ref_a[b] = vals[b];
                b++;
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        check("load_done", b > last_beat, 1'b1);
        err_m = err_m | (last_beat != SIZE - 1);
        #1;
        check("load_idle", busy, 1'b0);
        check("load_err", load_err, err_m);
        for (int n = 0; n < SIZE; n++)
            check("load_mem", s ? mem_b[n] : mem_a[n], s ? ref_b[n] : ref_a[n]);
    endtask

    task automatic run_calc();
        logic [SIZE_LOG-1:0] ea [$];
        logic [SIZE_LOG-1:0] eb [$];
        logic [SIZE_LOG-1:0] wq [$];
        int nen = 0;
        int nclr = 0;
        int cyc;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ref_r[i*DIM+j] = '0;
                for (int k = 0; k < DIM; k++) begin
                    ea.push_back(SIZE_LOG'(i*DIM + k));
                    eb.push_back(SIZE_LOG'(k*DIM + j));
                    ref_r[i*DIM+j] += ref_a[i*DIM+k] * ref_b[k*DIM+j];
                end
            end
        start = 1'b1;
        #1;
        tick();
        start = 1'b0;
        for (cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (en_R && !rw_R) break;
            if (cyc < SIZE * DIM)
                check("calc_issue", {en_A, en_B, rw_A, rw_B, addr_A, addr_B}, {4'b1100, ea[cyc], eb[cyc]});
            nen += int'(mac_en);
            nclr += int'(mac_en && mac_clear);
            if (en_R && rw_R) wq.push_back(addr_R);
            tick();
        end
        check("calc_latency", cyc, SIZE * DIM + 2);
        check("mac_en_count", nen, SIZE * DIM);
        check("mac_clear_count", nclr, SIZE);
        check("r_write_count", wq.size(), SIZE);
        foreach (wq[n]) check("r_write_addr", wq[n], n);
        for (int n = 0; n < SIZE; n++) check("r_value", mem_r[n], ref_r[n]);
`ifdef MAT_MUL_CTRL_PERF_CNT_EN
        check("calc_cycles", calc_cycles, SIZE * DIM + 2);
`endif
    endtask

    task automatic run_out(input int mode);
        int beat = 0;
        int ndone = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic [31:0] held = '0;
        while (cyc < 200 && beat < SIZE) begin
            m_tready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
            #1;
            if (stall) check("out_hold", {m_tvalid, r_dout}, {1'b1, held});
            ndone += int'(done);
            if (m_tvalid) begin
                if (m_tready) begin
                    check("out_data", r_dout, ref_r[beat]);
                    check("out_last", m_tlast, beat == SIZE - 1);
                    beat++;
                end
                held = r_dout;
            end
            stall = m_tvalid && !m_tready;
            tick();
            cyc++;
        end
        m_tready = 1'b0;
        check("out_beats", beat, SIZE);
        check("done_early", ndone, 0);
        #1;
        check("done_pulse", {done, busy}, 2'b10);
        tick();
        check("done_clear", done, 1'b0);
    endtask

    initial begin
        logic [31:0] va [SIZE];
        logic [31:0] vb [SIZE];
        int rw0;
        aresetn = 1'b0;
        repeat (3) tick();
        check("reset_outs", outs, '0);
`ifdef MAT_MUL_CTRL_PERF_CNT_EN
        check("reset_calc_cycles", calc_cycles, '0);
`endif
        aresetn = 1'b1;
        tick();
        va = '{1, 2, 3, 4};
        vb = '{5, 6, 7, 8};
        load(1'b0, SIZE - 1, va, 1'b0);
        load(1'b1, SIZE - 1, vb, 1'b1);
        run_calc();
        run_out(1);
        repeat (2) begin
            foreach (va[n]) begin
                va[n] = $urandom_range(0, 255);
                vb[n] = $urandom_range(0, 255);
            end
            load(1'b0, SIZE - 1, va, 1'b0);
            load(1'b1, SIZE - 1, vb, 1'b0);
            run_calc();
            run_out(2);
        end
        foreach (va[n]) va[n] = $urandom_range(0, 255);
        load(1'b0, 1, va, 1'b0);
        load(1'b1, SIZE - 1, vb, 1'b0);
        run_calc();
        run_out(0);
        rw0 = r_writes;
        start = 1'b1;
        #1;
        tick();
        start = 1'b0;
        #1 check("abort_busy", busy, 1'b1);
        repeat (2) tick();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        err_m = 1'b0;
        #1 check("abort_outs", outs, '0);
        repeat (6) tick();
        check("abort_no_rwrite", r_writes, rw0);
        foreach (va[n]) begin
            va[n] = $urandom_range(0, 255);
            vb[n] = $urandom_range(0, 255);
        end
        load(1'b1, SIZE - 1, vb, 1'b0);
        load(1'b0, SIZE - 1, va, 1'b0);
        run_calc();
        run_out(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
